// File: rtl/mdu_pkg.sv
// Shared MDU op codes and sequencer state encoding.
// The decoder and the MDU sequencer both import these constants.
package mdu_pkg;

  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic is_arith_op(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
  endfunction

  function automatic logic is_mult_op(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_MULTU};
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> MDU sequencer signal bundle.
// The EX stage is the master; mdu_ctrl is the slave.
interface mdu_ctrl_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, op, srcA, srcB, cancel,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, op, srcA, srcB, cancel,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: latched op/operands -> {hi, lo} plus a divide-by-zero flag.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;

  assign a_s  = a;
  assign b_s  = b;
  assign a_sx = {{32{a[31]}}, a};
  assign b_sx = {{32{b[31]}}, b};

  always_comb begin
    result   = '0;
    div_zero = 1'b0;
    case (op)
      MDU_MULT:  result = a_sx * b_sx;
      MDU_MULTU: result = {32'd0, a} * {32'd0, b};
      MDU_DIV: begin
        if (b == 32'd0) begin
          div_zero = 1'b1;
        // The one signed quotient that overflows; pin it so no tool-specific behaviour leaks in.
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          result = {32'h0000_0000, 32'h8000_0000};
        end else begin
          result = {a_s % b_s, a_s / b_s};
        end
      end
      MDU_DIVU: begin
        if (b == 32'd0) begin
          div_zero = 1'b1;
        end else begin
          result = {a % b, a / b};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer for the EX stage: latches a request, counts the
// op latency while busy, then commits HI/LO with a one-cycle done pulse.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  mdu_ctrl_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [3:0]         op_reg;
  logic [31:0]        a_reg, b_reg;
  logic [31:0]        hi_reg, lo_reg;
  logic               done_reg, done_next;
  logic               accept, commit, mthi_we, mtlo_we;
  logic [63:0]        arith_result;
  logic               div_zero;

  mdu_arith u_arith (
    .op       (op_reg),
    .a        (a_reg),
    .b        (b_reg),
    .result   (arith_result),
    .div_zero (div_zero)
  );

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.cancel && is_arith_op(bus.op)) begin
          accept     = 1'b1;
          state_next = BUSY;
          count_next = is_mult_op(bus.op) ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
        end
      end
      BUSY: begin
        if (count_reg == '0) begin
          commit     = 1'b1;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          count_next = count_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // HI/LO moves bypass the sequencer but are dropped while an op is in flight.
  assign mthi_we = (state_reg == IDLE) && !bus.cancel && (bus.op == MDU_MTHI);
  assign mtlo_we = (state_reg == IDLE) && !bus.cancel && (bus.op == MDU_MTLO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      op_reg    <= MDU_NOP;
      a_reg     <= '0;
      b_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      done_reg  <= done_next;
      if (accept) begin
        op_reg <= bus.op;
        a_reg  <= bus.srcA;
        b_reg  <= bus.srcB;
      end
      if (commit && !div_zero) begin
        hi_reg <= arith_result[63:32];
        lo_reg <= arith_result[31:0];
      end
      if (mthi_we) hi_reg <= bus.srcA;
      if (mtlo_we) lo_reg <= bus.srcA;
    end
  end

  assign bus.busy = (state_reg == BUSY);
  assign bus.done = done_reg;
  assign bus.HI   = hi_reg;
  assign bus.LO   = lo_reg;

  req_while_busy_a: assert property (@(posedge clk) disable iff (reset)
      (state_reg == BUSY) |-> !((bus.start && is_arith_op(bus.op)) ||
                                bus.op == MDU_MTHI || bus.op == MDU_MTLO))
    else $warning("mdu_ctrl: MDU request while busy ignored");

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected {HI,LO} queued at issue, popped at done.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.start = 1'b0; bus.op = MDU_NOP; bus.srcA = '0; bus.srcB = '0; bus.cancel = 1'b0;
  endtask

  // Called at a negedge: issue one request, then watch until done (bounded).
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy, output bit seen, output bit busy_at_done);
    bus.start = 1'b1; bus.op = o; bus.srcA = a; bus.srcB = b; bus.cancel = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
    nbusy = 0; seen = 1'b0; busy_at_done = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        busy_at_done = bus.busy;
      end else if (bus.busy) begin
        nbusy++;
      end
    end
    $display("[TB] op=%0d srcA=%h srcB=%h busy_cycles=%0d done=%0b HI=%h LO=%h",
             o, a, b, nbusy, seen, bus.HI, bus.LO);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b required 0", bus.done); end
    tests_run++; if (bus.HI !== 32'h0) begin tests_failed++; $display("FAIL reset_hi: got %h required 0", bus.HI); end
    tests_run++; if (bus.LO !== 32'h0) begin tests_failed++; $display("FAIL reset_lo: got %h required 0", bus.LO); end
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL post_reset_busy: got %b required 0", bus.busy); end
    $display("[TB] reset released");
  endtask

  task automatic test_mult();
    int nb; bit seen, bad; logic [63:0] e;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFE});
    run_op(MDU_MULT, 32'hFFFF_FFFF, 32'd2, nb, seen, bad);
    e = exp_q.pop_front(); {exp_hi, exp_lo} = e;
    tests_run++; if (nb !== MULT_N) begin tests_failed++; $display("FAIL mult_busy_cycles: got %0d required %0d", nb, MULT_N); end
    tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL mult_done: got %b required 1", seen); end
    tests_run++; if (bad !== 1'b0) begin tests_failed++; $display("FAIL mult_busy_at_done: got %b required 0", bad); end
    tests_run++; if ({bus.HI, bus.LO} !== e) begin tests_failed++; $display("FAIL mult_result: got %h required %h", {bus.HI, bus.LO}, e); end
    @(negedge clk);
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL mult_done_pulse: got %b required 0", bus.done); end
  endtask

  task automatic test_multu();
    int nb; bit seen, bad; logic [63:0] e;
    exp_q.push_back({32'h0000_0001, 32'hFFFF_FFFE});
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, nb, seen, bad);
    e = exp_q.pop_front(); {exp_hi, exp_lo} = e;
    tests_run++; if (nb !== MULT_N) begin tests_failed++; $display("FAIL multu_busy_cycles: got %0d required %0d", nb, MULT_N); end
    tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL multu_done: got %b required 1", seen); end
    tests_run++; if ({bus.HI, bus.LO} !== e) begin tests_failed++; $display("FAIL multu_result: got %h required %h", {bus.HI, bus.LO}, e); end
  endtask

  task automatic test_div();
    int nb; bit seen, bad; logic [63:0] e;
    logic [3:0]  ops[4] = '{MDU_DIV, MDU_DIVU, MDU_DIV, MDU_DIV};
    logic [31:0] as[4]  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd7};
    logic [31:0] bs[4]  = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    // -7/2, 7/0 (keeps previous HI/LO), overflow case, 7/-2
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    exp_q.push_back({32'h0000_0000, 32'h8000_0000});
    exp_q.push_back({32'h0000_0001, 32'hFFFF_FFFD});
    for (int k = 0; k < 4; k++) begin
      run_op(ops[k], as[k], bs[k], nb, seen, bad);
      e = exp_q.pop_front(); {exp_hi, exp_lo} = e;
      tests_run++; if (nb !== DIV_N) begin tests_failed++; $display("FAIL div%0d_busy_cycles: got %0d required %0d", k, nb, DIV_N); end
      tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL div%0d_done: got %b required 1", k, seen); end
      tests_run++; if ({bus.HI, bus.LO} !== e) begin tests_failed++; $display("FAIL div%0d_result: got %h required %h", k, {bus.HI, bus.LO}, e); end
    end
  endtask

  task automatic test_cancel_mtlo();
    bus.start = 1'b1; bus.op = MDU_MULT; bus.srcA = 32'd3; bus.srcB = 32'd4; bus.cancel = 1'b1;
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL cancel_busy: got %b required 0", bus.busy); end
    tests_run++; if ({bus.HI, bus.LO} !== {exp_hi, exp_lo}) begin tests_failed++; $display("FAIL cancel_hilo: got %h required %h", {bus.HI, bus.LO}, {exp_hi, exp_lo}); end
    $display("[TB] cancelled MULT busy=%b HI=%h LO=%h", bus.busy, bus.HI, bus.LO);
    bus.op = MDU_MTLO; bus.srcA = 32'h0000_1234;
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    exp_lo = 32'h0000_1234;
    tests_run++; if (bus.LO !== exp_lo) begin tests_failed++; $display("FAIL mtlo_lo: got %h required %h", bus.LO, exp_lo); end
    tests_run++; if (bus.HI !== exp_hi) begin tests_failed++; $display("FAIL mtlo_hi: got %h required %h", bus.HI, exp_hi); end
    tests_run++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin tests_failed++; $display("FAIL mtlo_flags: got busy=%b done=%b required 0/0", bus.busy, bus.done); end
    $display("[TB] MTLO srcA=00001234 LO=%h", bus.LO);
    bus.op = MDU_MTHI; bus.srcA = 32'h5555_AAAA; bus.cancel = 1'b1;
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    tests_run++; if (bus.HI !== exp_hi) begin tests_failed++; $display("FAIL mthi_cancel: got %h required %h", bus.HI, exp_hi); end
    $display("[TB] cancelled MTHI HI=%h", bus.HI);
  endtask

  task automatic test_operand_hold();
    int nb; bit seen; logic [63:0] e;
    exp_q.push_back({32'd2, 32'd14});
    bus.start = 1'b1; bus.op = MDU_DIV; bus.srcA = 32'd100; bus.srcB = 32'd7;
    @(posedge clk); #1; idle_inputs();
    nb = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else if (bus.busy) nb++;
      bus.srcA = $urandom; bus.srcB = $urandom;
      bus.op   = (i == 2 && !seen) ? MDU_MTHI : MDU_NOP;
    end
    idle_inputs();
    e = exp_q.pop_front(); {exp_hi, exp_lo} = e;
    $display("[TB] DIV 100/7 with toggling operands busy_cycles=%0d HI=%h LO=%h", nb, bus.HI, bus.LO);
    tests_run++; if (nb !== DIV_N) begin tests_failed++; $display("FAIL hold_busy_cycles: got %0d required %0d", nb, DIV_N); end
    tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL hold_done: got %b required 1", seen); end
    tests_run++; if ({bus.HI, bus.LO} !== e) begin tests_failed++; $display("FAIL hold_result: got %h required %h", {bus.HI, bus.LO}, e); end
  endtask

  task automatic test_reset_mid();
    int nb, nd; bit seen, bad; logic [63:0] e;
    bus.start = 1'b1; bus.op = MDU_DIV; bus.srcA = 32'd100; bus.srcB = 32'd3;
    @(posedge clk); #1; idle_inputs();
    nb = 0;
    for (int i = 0; i < 20 && nb < 4; i++) begin
      @(negedge clk);
      if (bus.busy) nb++;
    end
    reset = 1'b1; #1;
    exp_hi = '0; exp_lo = '0;
    tests_run++; if (nb !== 4) begin tests_failed++; $display("FAIL rmid_reach: got %0d busy cycles required 4", nb); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy: got %b required 0", bus.busy); end
    tests_run++; if ({bus.HI, bus.LO} !== 64'h0) begin tests_failed++; $display("FAIL rmid_hilo: got %h required 0", {bus.HI, bus.LO}); end
    $display("[TB] reset mid-DIV busy=%b HI=%h LO=%h", bus.busy, bus.HI, bus.LO);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    tests_run++; if (nd !== 0) begin tests_failed++; $display("FAIL rmid_no_done: got %0d done pulses required 0", nd); end
    exp_q.push_back({32'd0, 32'd42});
    run_op(MDU_MULT, 32'd6, 32'd7, nb, seen, bad);
    e = exp_q.pop_front(); {exp_hi, exp_lo} = e;
    tests_run++; if (nb !== MULT_N) begin tests_failed++; $display("FAIL rmid_mult_busy: got %0d required %0d", nb, MULT_N); end
    tests_run++; if ({bus.HI, bus.LO} !== e) begin tests_failed++; $display("FAIL rmid_mult_result: got %h required %h", {bus.HI, bus.LO}, e); end
  endtask

  task automatic test_back_to_back();
    int nb; bit seen, bad; logic [63:0] e;
    logic [31:0] a, b;
    logic [3:0]  o;
    // run_op returns in the done cycle, so the next issue lands in that same cycle.
    for (int k = 0; k < 4; k++) begin
      a = $urandom;
      b = 32'($urandom_range(1, 100000));
      o = (k % 2 == 0) ? MDU_MULTU : MDU_DIVU;
      if (o == MDU_MULTU) exp_q.push_back({32'd0, a} * {32'd0, b});
      else                exp_q.push_back({a % b, a / b});
      run_op(o, a, b, nb, seen, bad);
      e = exp_q.pop_front(); {exp_hi, exp_lo} = e;
      tests_run++; if (nb !== ((o == MDU_MULTU) ? MULT_N : DIV_N)) begin tests_failed++; $display("FAIL b2b%0d_busy: got %0d", k, nb); end
      tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL b2b%0d_done: got %b required 1", k, seen); end
      tests_run++; if ({bus.HI, bus.LO} !== e) begin tests_failed++; $display("FAIL b2b%0d_result: got %h required %h", k, {bus.HI, bus.LO}, e); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_cancel_mtlo();
    test_operand_hold();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
